// File: rtl/pooled_map_collector.sv
// Collects per-kernel pooled pixels into one map per kernel, then replays all maps
// channel-major in raster order as a single valid/ready stream.
module pooled_map_collector #(
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    parameter int BitSize            = 32,
    parameter int MapWidth           = 2,
    localparam int ChW               = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
    input  logic                                         clk,
    input  logic                                         res_n,
    input  logic [NumberOfK-1:0]                         in_valid,
    input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
    output logic                                         in_ready,
    input  logic                                         out_ready,
    output logic                                         out_valid,
    output logic [BitSize-1:0]                           out_data,
    output logic [ChW-1:0]                               out_channel,
    output logic                                         out_last,
    output logic                                         overflow,
    output logic                                         lane_clash
);
    localparam int MapSize = MapWidth * MapWidth;
    localparam int CntW    = $clog2(MapSize + 1);
    localparam int IdxW    = (MapSize > 1) ? $clog2(MapSize) : 1;
    localparam logic [CntW-1:0] CntFull = CntW'(MapSize);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(MapSize - 1);
    localparam logic [ChW-1:0]  ChLast  = ChW'(NumberOfK - 1);

    typedef enum logic {
        ST_FILL,
        ST_DRAIN
    } state_t;

    state_t                 state_q;
    logic [CntW-1:0]        wr_cnt_q [NumberOfK];
    logic [CntW-1:0]        wr_cnt_d [NumberOfK];
    logic [IdxW-1:0]        rd_idx_q;
    logic [ChW-1:0]         rd_ch_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [BitSize-1:0]     out_data_q;
    logic [ChW-1:0]         out_channel_q;
    logic                   out_last_q;
    logic                   overflow_q;
    logic                   lane_clash_q;

    logic                   fill_st;
    logic [NumberOfK-1:0]   wr_en;
    logic [NumberOfK-1:0]   full_d;
    logic [BitSize-1:0]     rd_words [NumberOfK];
    logic [ProcessingElements-1:0] lane_multi;
    logic                   any_drop;
    logic                   last_word;

    genvar gi, gj;

    assign fill_st = (state_q == ST_FILL);

    // A lane is clashing when more than one of the kernels mapped onto it strobes at once.
    for (gi = 0; gi < ProcessingElements; gi++) begin : g_lane
        logic [NumberOfK-1:0] sharers;
        for (gj = 0; gj < NumberOfK; gj++) begin : g_k
            if ((gj % ProcessingElements) == gi) begin : g_on
                assign sharers[gj] = in_valid[gj];
            end else begin : g_off
                assign sharers[gj] = 1'b0;
            end
        end
        assign lane_multi[gi] = |(sharers & (sharers - NumberOfK'(1)));
    end

    // One map memory per kernel so every kernel can be written in the same cycle.
    for (gi = 0; gi < NumberOfK; gi++) begin : g_kern
        logic [BitSize-1:0] mem [MapSize];

        assign wr_en[gi]    = fill_st && in_valid[gi] && (wr_cnt_q[gi] != CntFull);
        assign wr_cnt_d[gi] = wr_cnt_q[gi] + CntW'(wr_en[gi]);
        assign full_d[gi]   = (wr_cnt_d[gi] == CntFull);

        always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
                mem[wr_cnt_q[gi][IdxW-1:0]] <= in_data[gi % ProcessingElements];
            end
        end

        assign rd_words[gi] = mem[rd_idx_q];
    end

    assign any_drop  = |(in_valid & ~wr_en);
    assign last_word = (rd_ch_q == ChLast) && (rd_idx_q == IdxLast);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q       <= ST_FILL;
            for (int k = 0; k < NumberOfK; k++) begin
                wr_cnt_q[k] <= '0;
            end
            rd_idx_q      <= '0;
            rd_ch_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
            overflow_q    <= 1'b0;
            lane_clash_q  <= 1'b0;
        end else begin
            if (any_drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_FILL: begin
                    for (int k = 0; k < NumberOfK; k++) begin
                        wr_cnt_q[k] <= wr_cnt_d[k];
                    end
                    if (|lane_multi) begin
                        lane_clash_q <= 1'b1;
                    end
                    if (&full_d) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The output register is refilled whenever it is empty or being consumed.
                    if (!out_valid_q || out_ready) begin
                        if (out_valid_q && out_last_q) begin
                            state_q     <= ST_FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            rd_idx_q    <= '0;
                            rd_ch_q     <= '0;
                            for (int k = 0; k < NumberOfK; k++) begin
                                wr_cnt_q[k] <= '0;
                            end
                        end else begin
                            out_valid_q   <= 1'b1;
                            out_data_q    <= rd_words[rd_ch_q];
                            out_channel_q <= rd_ch_q;
                            out_last_q    <= last_word;
                            if (rd_idx_q == IdxLast) begin
                                rd_idx_q <= '0;
                                rd_ch_q  <= rd_ch_q + ChW'(1);
                            end else begin
                                rd_idx_q <= rd_idx_q + IdxW'(1);
                            end
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_last    = out_last_q;
    assign overflow    = overflow_q;
    assign lane_clash  = lane_clash_q;

endmodule

// File: tb/tb_pooled_map_collector.sv
// Directed bench for pooled_map_collector: fill patterns, replay order, backpressure,
// overflow, lane clash and reset during replay.
module tb_pooled_map_collector;
    logic             clk = 1'b0;
    logic             res_n;
    logic [3:0]       in_valid;
    logic [1:0][31:0] in_data;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [1:0]       out_channel;
    logic             out_last;
    logic             overflow;
    logic             lane_clash;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_data [32];
    logic [1:0]  got_ch   [32];
    logic        got_last [32];
    int          got_cyc  [32];
    int          n_got;
    bit          timed_out;
    logic [31:0] exp_mem  [4][4];

    pooled_map_collector #(
        .NumberOfK(4), .ProcessingElements(2), .BitSize(32), .MapWidth(2)
    ) dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_channel(out_channel), .out_last(out_last),
        .overflow(overflow), .lane_clash(lane_clash)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; the strobe is consumed by the next rising edge.
    task automatic push(input logic [3:0] v, input logic [31:0] l0, input logic [31:0] l1);
        in_valid   = v;
        in_data[0] = l0;
        in_data[1] = l1;
        @(negedge clk);
        in_valid   = '0;
    endtask

    task automatic push_k(input int k, input logic [31:0] d);
        push(4'(1 << k), (k % 2 == 0) ? d : 32'h0, (k % 2 == 1) ? d : 32'h0);
    endtask

    task automatic fill_all(input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                exp_mem[k][i] = base + 32'(16 * k + i);
                push_k(k, exp_mem[k][i]);
            end
        end
    endtask

    task automatic clear_got();
        for (int j = 0; j < 32; j++) begin
            got_data[j] = 'x;
            got_ch[j]   = 'x;
            got_last[j] = 1'bx;
            got_cyc[j]  = -1;
        end
        n_got     = 0;
        timed_out = 0;
    endtask

    task automatic record(input int cyc);
        got_data[n_got] = out_data;
        got_ch[n_got]   = out_channel;
        got_last[n_got] = out_last;
        got_cyc[n_got]  = cyc;
        n_got++;
    endtask

    // Records transfers with out_ready held high, stopping after the last word or max_xfers.
    task automatic drain_collect(input int max_xfers, input int max_cyc);
        int cyc;
        bit done;
        clear_got();
        cyc  = 0;
        done = 0;
        while (!done) begin
            out_ready = 1'b1;
            if (out_valid === 1'b1) begin
                record(cyc);
                if (out_last === 1'b1 || n_got >= max_xfers || n_got >= 32) done = 1;
            end
            @(negedge clk);
            cyc++;
            if (!done && cyc >= max_cyc) begin
                timed_out = 1;
                done      = 1;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        res_n     = 1'b0;
        @(negedge clk);
        res_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        res_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_channel, out_last, overflow, lane_clash, in_ready} !==
            {1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h ch=%0d last=%b ovf=%b clash=%b rdy=%b expected 0,0,0,0,0,0,1",
                     out_valid, out_data, out_channel, out_last, overflow, lane_clash, in_ready);
        end
        res_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        fill_all(32'h0);
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL t1_enter_drain: got ready=%b valid=%b expected 0 0", in_ready, out_valid);
        end
        drain_collect(16, 100);
        checks++;
        if (timed_out || n_got != 16) begin
            errors++;
            $display("FAIL t1_count: got %0d transfers (timeout=%0d) expected 16", n_got, timed_out);
        end
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({got_data[n], got_ch[n], got_last[n]} !== {exp_mem[n/4][n%4], 2'(n/4), n == 15}) begin
                errors++;
                $display("FAIL t1_word%0d: got %h/ch%0d/last%b expected %h/ch%0d/last%b",
                         n, got_data[n], got_ch[n], got_last[n], exp_mem[n/4][n%4], n/4, n == 15);
            end
            checks++;
            if (got_cyc[n] != n + 1) begin
                errors++;
                $display("FAIL t1_timing%0d: got cycle %0d expected %0d", n, got_cyc[n], n + 1);
            end
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL t1_done: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
        $display("test_round_robin: %0d words replayed", n_got);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            exp_mem[0][i] = 32'hA0 + 32'(i);
            exp_mem[1][i] = 32'hB0 + 32'(i);
            push(4'b0011, exp_mem[0][i], exp_mem[1][i]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_mem[2][i] = 32'hC0 + 32'(i);
            exp_mem[3][i] = 32'hD0 + 32'(i);
            push(4'b1100, exp_mem[2][i], exp_mem[3][i]);
        end
        checks++;
        if ({lane_clash, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL t2_flags: got clash=%b ovf=%b expected 0 0", lane_clash, overflow);
        end
        drain_collect(16, 100);
        checks++;
        if (timed_out || n_got != 16) begin
            errors++;
            $display("FAIL t2_count: got %0d transfers expected 16", n_got);
        end
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({got_data[n], got_ch[n], got_last[n]} !== {exp_mem[n/4][n%4], 2'(n/4), n == 15}) begin
                errors++;
                $display("FAIL t2_word%0d: got %h/ch%0d expected %h/ch%0d",
                         n, got_data[n], got_ch[n], exp_mem[n/4][n%4], n/4);
            end
        end
        $display("test_simultaneous: %0d words replayed", n_got);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit done;
        bit prev_stall;
        logic [31:0] prev_d;
        logic [1:0]  prev_c;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                exp_mem[k][i] = 32'h100 + 32'(16 * k + i);
                push_k(k, exp_mem[k][i]);
            end
        end
        clear_got();
        cyc = 0; done = 0; prev_stall = 0; prev_d = '0; prev_c = '0;
        while (!done && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_data, out_channel} !== {1'b1, prev_d, prev_c}) begin
                    errors++;
                    $display("FAIL t3_hold: got valid=%b %h/ch%0d expected valid=1 %h/ch%0d",
                             out_valid, out_data, out_channel, prev_d, prev_c);
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_d = out_data;
            prev_c = out_channel;
            if (out_valid === 1'b1 && out_ready) begin
                record(cyc);
                if (out_last === 1'b1 || n_got >= 32) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (!done || n_got != 16) begin
            errors++;
            $display("FAIL t3_count: got %0d transfers expected 16", n_got);
        end
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({got_data[n], got_ch[n], got_last[n]} !== {exp_mem[n/4][n%4], 2'(n/4), n == 15}) begin
                errors++;
                $display("FAIL t3_word%0d: got %h/ch%0d expected %h/ch%0d",
                         n, got_data[n], got_ch[n], exp_mem[n/4][n%4], n/4);
            end
        end
        $display("test_backpressure: %0d transfers", n_got);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_k(1, 32'h40 + 32'(i));
            if (i == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL t4_no_ovf: got %b expected 0", overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_ovf_fill: got %b expected 1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            exp_mem[1][i] = 32'h40 + 32'(i);
            exp_mem[0][i] = 32'h30 + 32'(i);
            exp_mem[2][i] = 32'h50 + 32'(i);
            exp_mem[3][i] = 32'h60 + 32'(i);
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 1) begin
                for (int i = 0; i < 4; i++) push_k(k, exp_mem[k][i]);
            end
        end
        drain_collect(16, 100);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({got_data[n], got_ch[n]} !== {exp_mem[n/4][n%4], 2'(n/4)}) begin
                errors++;
                $display("FAIL t4_word%0d: got %h/ch%0d expected %h/ch%0d",
                         n, got_data[n], got_ch[n], exp_mem[n/4][n%4], n/4);
            end
        end
        do_reset();
        fill_all(32'h0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL t4_clean: got %b expected 0", overflow);
        end
        push(4'b1111, 32'hDEAD, 32'hBEEF);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_ovf_drain: got %b expected 1", overflow);
        end
        drain_collect(16, 100);
        checks++;
        if (n_got != 16) begin
            errors++;
            $display("FAIL t4_drain_count: got %0d expected 16", n_got);
        end
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (got_data[n] !== exp_mem[n/4][n%4]) begin
                errors++;
                $display("FAIL t4_drain_word%0d: got %h expected %h", n, got_data[n], exp_mem[n/4][n%4]);
            end
        end
        $display("test_overflow done");
    endtask

    task automatic test_lane_clash();
        do_reset();
        push(4'b0101, 32'h55, 32'h0);
        checks++;
        if ({lane_clash, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL t5_clash: got clash=%b ovf=%b expected 1 0", lane_clash, overflow);
        end
        exp_mem[0][0] = 32'h55;
        exp_mem[2][0] = 32'h55;
        for (int i = 1; i < 4; i++) begin
            exp_mem[0][i] = 32'h10 + 32'(i);
            exp_mem[2][i] = 32'h20 + 32'(i);
            push_k(0, exp_mem[0][i]);
            push_k(2, exp_mem[2][i]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_mem[1][i] = 32'h30 + 32'(i);
            exp_mem[3][i] = 32'h40 + 32'(i);
            push_k(1, exp_mem[1][i]);
            push_k(3, exp_mem[3][i]);
        end
        drain_collect(16, 100);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({got_data[n], got_ch[n]} !== {exp_mem[n/4][n%4], 2'(n/4)}) begin
                errors++;
                $display("FAIL t5_word%0d: got %h/ch%0d expected %h/ch%0d",
                         n, got_data[n], got_ch[n], exp_mem[n/4][n%4], n/4);
            end
        end
        checks++;
        if (lane_clash !== 1'b1) begin
            errors++;
            $display("FAIL t5_sticky: got %b expected 1", lane_clash);
        end
        $display("test_lane_clash done");
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        fill_all(32'h200);
        drain_collect(7, 100);
        checks++;
        if (n_got != 7 || got_data[6] !== exp_mem[1][2]) begin
            errors++;
            $display("FAIL t6_partial: got %0d words last %h expected 7 words last %h", n_got, got_data[6], exp_mem[1][2]);
        end
        res_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_channel, out_last, overflow, lane_clash, in_ready} !==
            {1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL t6_reset: got v=%b d=%h ch=%0d last=%b ovf=%b clash=%b rdy=%b expected 0,0,0,0,0,0,1",
                     out_valid, out_data, out_channel, out_last, overflow, lane_clash, in_ready);
        end
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        fill_all(32'h300);
        drain_collect(16, 100);
        checks++;
        if (timed_out || n_got != 16) begin
            errors++;
            $display("FAIL t6_count: got %0d transfers expected 16", n_got);
        end
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({got_data[n], got_ch[n], got_last[n]} !== {exp_mem[n/4][n%4], 2'(n/4), n == 15}) begin
                errors++;
                $display("FAIL t6_word%0d: got %h/ch%0d expected %h/ch%0d",
                         n, got_data[n], got_ch[n], exp_mem[n/4][n%4], n/4);
            end
        end
        $display("test_reset_mid_drain done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_lane_clash();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
